// File: rtl/interrupt_tracker.sv
// Multi-channel interrupt request tracker: edge/level qualification, priority
// presentation to the sequencer, and a nesting stack of running handlers.
module interrupt_tracker #(
  parameter int unsigned       NUM_CH     = 4,
  parameter logic [NUM_CH-1:0] EDGE_MASK  = NUM_CH'(1),
  parameter logic [NUM_CH-1:0] NMASK_MASK = NUM_CH'(1),
  parameter int unsigned       MAX_NEST   = 4,
  localparam int unsigned      IDW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned      DW         = $clog2(MAX_NEST + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable_ffs,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic              i_flag,
  input  logic              int_ack,
  input  logic              int_done,
  output logic              pending_valid,
  output logic [IDW-1:0]    pending_id,
  output logic [NUM_CH-1:0] running,
  output logic [IDW-1:0]    active_id,
  output logic [DW-1:0]     nest_depth
);

  localparam int unsigned SW = (MAX_NEST > 1) ? $clog2(MAX_NEST) : 1;

  logic [NUM_CH-1:0] prevIrq;
  logic [NUM_CH-1:0] edgeLatch;
  logic [NUM_CH-1:0] latchNext;
  logic [NUM_CH-1:0] newEdge;
  logic [NUM_CH-1:0] ackClr;
  logic [NUM_CH-1:0] eligible;
  logic [IDW-1:0]    stack [MAX_NEST];
  logic              ackAcc;
  logic              doneAcc;
  logic [SW-1:0]     pushIdx;
  logic [SW-1:0]     topIdx;
  logic [SW-1:0]     belowIdx;

  always_comb begin
    eligible      = '0;
    pending_valid = 1'b0;
    pending_id    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if ((EDGE_MASK[c] ? edgeLatch[c] : irq_in[c]) && !running[c] &&
          (NMASK_MASK[c] || !i_flag) &&
          (nest_depth == '0 || c < 32'(active_id)) &&
          (32'(nest_depth) < MAX_NEST))
        eligible[c] = 1'b1;
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (eligible[c] && !pending_valid) begin
        pending_valid = 1'b1;
        pending_id    = IDW'(c);
      end
    end
  end

  always_comb begin
    ackAcc  = int_ack & pending_valid & enable_ffs;
    doneAcc = int_done & enable_ffs & (nest_depth != '0);
    ackClr  = '0;
    if (ackAcc)
      ackClr[pending_id] = 1'b1;
    newEdge   = irq_in & ~prevIrq & EDGE_MASK;
    // a fresh edge in the ack cycle re-arms the latch it would otherwise clear
    latchNext = (edgeLatch & ~ackClr) | newEdge;
    pushIdx   = SW'(nest_depth);
    topIdx    = SW'(nest_depth - DW'(1));
    belowIdx  = SW'(nest_depth - DW'(2));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prevIrq    <= '0;
      edgeLatch  <= '0;
      running    <= '0;
      active_id  <= '0;
      nest_depth <= '0;
      for (int unsigned i = 0; i < MAX_NEST; i++)
        stack[i] <= '0;
    end else if (enable_ffs) begin
      prevIrq   <= irq_in;
      edgeLatch <= latchNext;
      if (ackAcc && doneAcc) begin
        // pop followed by push reduces to replacing the top entry in place
        running[active_id]  <= 1'b0;
        running[pending_id] <= 1'b1;
        stack[topIdx]       <= pending_id;
        active_id           <= pending_id;
      end else if (ackAcc) begin
        running[pending_id] <= 1'b1;
        stack[pushIdx]      <= pending_id;
        active_id           <= pending_id;
        nest_depth          <= nest_depth + 1'b1;
      end else if (doneAcc) begin
        running[active_id] <= 1'b0;
        nest_depth         <= nest_depth - 1'b1;
        active_id          <= (nest_depth > DW'(1)) ? stack[belowIdx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_tracker.sv
// Directed bench for interrupt_tracker; second instance uses MAX_NEST = 2.
module tb_interrupt_tracker;

  logic       clk;
  logic       nrst;
  logic       enable_ffs;
  logic [3:0] irq_in;
  logic       i_flag;
  logic       int_ack;
  logic       int_done;

  logic       pv1, pv2;
  logic [1:0] pid1, pid2;
  logic [3:0] run1, run2;
  logic [1:0] aid1, aid2;
  logic [2:0] nd1;
  logic [1:0] nd2;

  logic [11:0] st1, st2, exp;
  int vecs = 0;
  int errs = 0;

  assign st1 = {pv1, pid1, run1, aid1, nd1};
  assign st2 = {pv2, pid2, run2, aid2, 1'b0, nd2};

  interrupt_tracker #(.NUM_CH(4), .EDGE_MASK(4'b0001), .NMASK_MASK(4'b0001), .MAX_NEST(4)) dut (
    .clk(clk), .nrst(nrst), .enable_ffs(enable_ffs), .irq_in(irq_in), .i_flag(i_flag),
    .int_ack(int_ack), .int_done(int_done), .pending_valid(pv1), .pending_id(pid1),
    .running(run1), .active_id(aid1), .nest_depth(nd1));

  interrupt_tracker #(.NUM_CH(4), .EDGE_MASK(4'b0001), .NMASK_MASK(4'b0001), .MAX_NEST(2)) dut2 (
    .clk(clk), .nrst(nrst), .enable_ffs(enable_ffs), .irq_in(irq_in), .i_flag(i_flag),
    .int_ack(int_ack), .int_done(int_done), .pending_valid(pv2), .pending_id(pid2),
    .running(run2), .active_id(aid2), .nest_depth(nd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    #2;
    nrst = 1'b0; enable_ffs = 1'b1; irq_in = '0; i_flag = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    #3;
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    nrst = 1'b0; enable_ffs = 1'b1; irq_in = '0; i_flag = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    #3;
    exp = '0; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL reset_state: got %h want %h", st1, exp); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_edge_latch;
    doReset();
    i_flag = 1'b1; irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000; #1;
    exp = {1'b1, 2'd0, 4'b0000, 2'd0, 3'd0}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL edge_present: got %h want %h", st1, exp); end
    tick();
    exp = {1'b1, 2'd0, 4'b0000, 2'd0, 3'd0}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL edge_held: got %h want %h", st1, exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; #1;
    exp = {1'b0, 2'd0, 4'b0001, 2'd0, 3'd1}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL edge_ack: got %h want %h", st1, exp); end
    int_done = 1'b1;
    tick();
    int_done = 1'b0; #1;
    exp = '0; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL edge_done: got %h want %h", st1, exp); end
  endtask

  task automatic test_masking;
    doReset();
    i_flag = 1'b1; irq_in = 4'b0100; #1;
    exp = '0; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL mask_blocked: got %h want %h", st1, exp); end
    i_flag = 1'b0; #1;
    exp = {1'b1, 2'd2, 4'b0000, 2'd0, 3'd0}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL mask_open: got %h want %h", st1, exp); end
    irq_in = 4'b0000; #1;
    exp = '0; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL mask_level_drop: got %h want %h", st1, exp); end
  endtask

  task automatic test_preemption;
    doReset();
    irq_in = 4'b1000; #1;
    exp = {1'b1, 2'd3, 4'b0000, 2'd0, 3'd0}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL pre_ch3_present: got %h want %h", st1, exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; irq_in = 4'b1011;
    tick();
    irq_in = 4'b1010; #1;
    exp = {1'b1, 2'd0, 4'b1000, 2'd3, 3'd1}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL pre_prio0: got %h want %h", st1, exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; #1;
    exp = {1'b0, 2'd0, 4'b1001, 2'd0, 3'd2}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL pre_nested: got %h want %h", st1, exp); end
    int_done = 1'b1;
    tick();
    int_done = 1'b0; #1;
    exp = {1'b1, 2'd1, 4'b1000, 2'd3, 3'd1}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL pre_pop_ch1: got %h want %h", st1, exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; irq_in = 4'b1110; #1;
    exp = {1'b0, 2'd0, 4'b1010, 2'd1, 3'd2}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL pre_ch2_blocked: got %h want %h", st1, exp); end
  endtask

  task automatic test_nest_limit;
    doReset();
    irq_in = 4'b1000; int_ack = 1'b1;
    tick();
    irq_in = 4'b1100;
    tick();
    int_ack = 1'b0; irq_in = 4'b1101;
    tick();
    irq_in = 4'b1100; #1;
    exp = {1'b0, 2'd0, 4'b1100, 2'd2, 3'd2}; vecs++;
    if (st2 !== exp) begin errs++; $display("FAIL nest_full_blocked: got %h want %h", st2, exp); end
    exp = {1'b1, 2'd0, 4'b1100, 2'd2, 3'd2}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL nest_deep_open: got %h want %h", st1, exp); end
    int_done = 1'b1;
    tick();
    int_done = 1'b0; #1;
    exp = {1'b1, 2'd0, 4'b1000, 2'd3, 3'd1}; vecs++;
    if (st2 !== exp) begin errs++; $display("FAIL nest_after_done: got %h want %h", st2, exp); end
  endtask

  task automatic test_back_to_back;
    doReset();
    irq_in = 4'b0100; int_ack = 1'b1;
    tick();
    int_ack = 1'b0; irq_in = 4'b0110; #1;
    exp = {1'b1, 2'd1, 4'b0100, 2'd2, 3'd1}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL b2b_pre: got %h want %h", st1, exp); end
    int_ack = 1'b1; int_done = 1'b1;
    tick();
    int_ack = 1'b0; int_done = 1'b0; #1;
    exp = {1'b0, 2'd0, 4'b0010, 2'd1, 3'd1}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL b2b_swap: got %h want %h", st1, exp); end
    irq_in = 4'b0111;
    tick();
    irq_in = 4'b0110;
    tick();
    irq_in = 4'b0111; int_ack = 1'b1;
    tick();
    int_ack = 1'b0; irq_in = 4'b0110; #1;
    exp = {1'b0, 2'd0, 4'b0011, 2'd0, 3'd2}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL b2b_ack_edge: got %h want %h", st1, exp); end
    int_done = 1'b1;
    tick();
    int_done = 1'b0; #1;
    exp = {1'b1, 2'd0, 4'b0010, 2'd1, 3'd1}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL b2b_latch_kept: got %h want %h", st1, exp); end
  endtask

  task automatic test_enable;
    doReset();
    enable_ffs = 1'b0; irq_in = 4'b0001; int_ack = 1'b1;
    tick();
    irq_in = 4'b0000; int_ack = 1'b0;
    tick();
    exp = '0; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL en_stall: got %h want %h", st1, exp); end
    enable_ffs = 1'b1;
    tick();
    exp = '0; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL en_dropped_edge: got %h want %h", st1, exp); end
    enable_ffs = 1'b0; irq_in = 4'b0001;
    tick();
    exp = '0; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL en_stall_high: got %h want %h", st1, exp); end
    enable_ffs = 1'b1;
    tick();
    exp = {1'b1, 2'd0, 4'b0000, 2'd0, 3'd0}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL en_late_edge: got %h want %h", st1, exp); end
    enable_ffs = 1'b0; int_ack = 1'b1;
    tick();
    exp = {1'b1, 2'd0, 4'b0000, 2'd0, 3'd0}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL en_ack_ignored: got %h want %h", st1, exp); end
    enable_ffs = 1'b1;
    tick();
    int_ack = 1'b0; irq_in = 4'b0000; #1;
    exp = {1'b0, 2'd0, 4'b0001, 2'd0, 3'd1}; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL en_ack_taken: got %h want %h", st1, exp); end
    #2;
    nrst = 1'b0; #1;
    exp = '0; vecs++;
    if (st1 !== exp) begin errs++; $display("FAIL async_reset: got %h want %h", st1, exp); end
    #2;
    nrst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_edge_latch();
    test_masking();
    test_preemption();
    test_nest_limit();
    test_back_to_back();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
